// File: rtl/mac_feeder_sequencer.sv
// mac_feeder_sequencer: initiator for a MAC cell. Buffers operand pairs in a
// local FIFO and launches a dot-product job of length N. It then streams the
// N pairs gap-free, waits for the MAC result strobe, and returns the captured
// result on a valid/ready port. Bad lengths and a MAC that never answers come
// back as an error result.

// Operand-pair FIFO. Push and pop may happen in the same cycle. The ready flag
// is registered from the next-state count, so it never depends on this
// cycle's inputs.
module mac_feeder_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid_i,
  output logic                  push_ready_o,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ready_q;
  logic                  push;

  assign push         = push_valid_i && ready_q;
  assign push_ready_o = ready_q;
  assign head_o       = mem[rd_ptr_q];
  assign count_o      = count_q;

  // Next occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first; a path that skips the assignment would infer a latch.
    count_d = count_q;
    unique case ({push, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: ;
    endcase
  end

  // Storage array: written on push only, never reset.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset. Contents are only readable behind
    // the count, so clearing it would cost a reset net per bit for nothing.
    if (push) begin
      mem[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers, count and registered ready; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      ready_q <= (count_d != CNT_W'(DEPTH));
    end
  end

endmodule

// Job sequencer: IDLE -> FILL -> LAUNCH -> STREAM -> WAIT -> CAPTURE -> HOLD.
module mac_feeder_sequencer #(
  parameter int MULER_WIDTH  = 8,
  parameter int NUM_WIDTH    = 8,
  parameter int OUTPUT_WIDTH = 32,
  parameter int FIFO_DEPTH   = 16,
  parameter int TIMEOUT      = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         job_valid_i,
  output logic                         job_ready_o,
  input  logic [NUM_WIDTH-1:0]         job_len_i,
  input  logic                         op_valid_i,
  output logic                         op_ready_o,
  input  logic [MULER_WIDTH-1:0]       op_a_i,
  input  logic [MULER_WIDTH-1:0]       op_b_i,
  output logic                         mac_num_valid_o,
  output logic [NUM_WIDTH-1:0]         mac_num_o,
  output logic [1:0][MULER_WIDTH-1:0]  mac_data_o,
  input  logic                         mac_data_ready_i,
  input  logic [OUTPUT_WIDTH-1:0]      mac_result_i,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic [OUTPUT_WIDTH-1:0]      res_data_o,
  output logic                         res_err_o
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef logic [1:0][MULER_WIDTH-1:0] pair_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_LAUNCH,
    S_STREAM,
    S_WAIT,
    S_CAPTURE,
    S_HOLD
  } state_e;

  state_e                  state_q;
  logic [NUM_WIDTH-1:0]    len_q;
  logic [NUM_WIDTH-1:0]    left_q;
  logic [TMR_W-1:0]        timer_q;
  logic                    job_ready_q;
  logic                    mac_num_valid_q;
  logic [NUM_WIDTH-1:0]    mac_num_q;
  pair_t                   mac_data_q;
  logic                    res_valid_q;
  logic [OUTPUT_WIDTH-1:0] res_data_q;
  logic                    res_err_q;

  pair_t                   fifo_head;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_pop;
  logic                    len_bad;
  logic                    fifo_has_job;

  // Pair layout on the MAC side: element 0 is a, element 1 is b.
  mac_feeder_fifo #(
    .DATA_WIDTH (2 * MULER_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_valid_i (op_valid_i),
    .push_ready_o (op_ready_o),
    .push_data_i  ({op_b_i, op_a_i}),
    .pop_i        (fifo_pop),
    .head_o       (fifo_head),
    .count_o      (fifo_count)
  );

  // A zero-length job, or one longer than the FIFO can ever hold, is refused.
  assign len_bad      = (job_len_i == '0) || (32'(job_len_i) > FIFO_DEPTH);
  // Streaming cannot stall, so every pair of the job must already be resident.
  assign fifo_has_job = (32'(fifo_count) >= 32'(len_q));
  // One pop while launching (first pair) and one per stream cycle except the last.
  assign fifo_pop     = (state_q == S_LAUNCH) || ((state_q == S_STREAM) && (left_q != '0));

  assign job_ready_o     = job_ready_q;
  assign mac_num_valid_o = mac_num_valid_q;
  assign mac_num_o       = mac_num_q;
  assign mac_data_o      = mac_data_q;
  assign res_valid_o     = res_valid_q;
  assign res_data_o      = res_data_q;
  assign res_err_o       = res_err_q;

  // Job FSM with all outputs registered; a synchronous reset abandons any job.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      len_q           <= '0;
      left_q          <= '0;
      timer_q         <= '0;
      job_ready_q     <= 1'b0;
      mac_num_valid_q <= 1'b0;
      mac_num_q       <= '0;
      mac_data_q      <= '0;
      res_valid_q     <= 1'b0;
      res_data_q      <= '0;
      res_err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (job_ready_q && job_valid_i) begin
            job_ready_q <= 1'b0;
            len_q       <= job_len_i;
            if (len_bad) begin
              res_valid_q <= 1'b1;
              res_err_q   <= 1'b1;
              res_data_q  <= '0;
              state_q     <= S_HOLD;
            end else begin
              state_q <= S_FILL;
            end
          end else begin
            job_ready_q <= 1'b1;
          end
        end

        S_FILL: begin
          if (fifo_has_job) begin
            mac_num_valid_q <= 1'b1;
            mac_num_q       <= len_q;
            mac_data_q      <= '0;
            state_q         <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          mac_num_valid_q <= 1'b0;
          mac_data_q      <= fifo_head;
          left_q          <= len_q - NUM_WIDTH'(1);
          state_q         <= S_STREAM;
        end

        S_STREAM: begin
          if (left_q == '0) begin
            mac_data_q <= '0;
            timer_q    <= '0;
            state_q    <= S_WAIT;
          end else begin
            mac_data_q <= fifo_head;
            left_q     <= left_q - NUM_WIDTH'(1);
          end
        end

        S_WAIT: begin
          if (mac_data_ready_i) begin
            state_q <= S_CAPTURE;
          end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
            res_valid_q <= 1'b1;
            res_err_q   <= 1'b1;
            res_data_q  <= '0;
            state_q     <= S_HOLD;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end

        // The MAC registers its result on the data_ready edge, so it is
        // sampled one cycle later.
        S_CAPTURE: begin
          res_valid_q <= 1'b1;
          res_err_q   <= 1'b0;
          res_data_q  <= mac_result_i;
          state_q     <= S_HOLD;
        end

        S_HOLD: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            job_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_feeder_sequencer.sv
// Self-checking bench for mac_feeder_sequencer: table-driven jobs, hand-written
// corner sequences, and randomised jobs. A behavioural MAC checks the launch
// pulse and gap-free stream and produces the result.
module tb_mac_feeder_sequencer;
  localparam int MW    = 8;
  localparam int NW    = 8;
  localparam int OW    = 32;
  localparam int DEPTH = 16;
  localparam int TMO   = 255;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     job_valid_i = 1'b0;
  logic                     job_ready_o;
  logic [NW-1:0]            job_len_i = '0;
  logic                     op_valid_i = 1'b0;
  logic                     op_ready_o;
  logic [MW-1:0]            op_a_i = '0;
  logic [MW-1:0]            op_b_i = '0;
  logic                     mac_num_valid_o;
  logic [NW-1:0]            mac_num_o;
  logic [1:0][MW-1:0]       mac_data_o;
  logic                     mac_data_ready_i = 1'b0;
  logic [OW-1:0]            mac_result_i = 32'hDEAD_BEEF;
  logic                     res_valid_o;
  logic                     res_ready_i = 1'b0;
  logic [OW-1:0]            res_data_o;
  logic                     res_err_o;

  always #5 clk = ~clk;

  mac_feeder_sequencer #(
    .MULER_WIDTH (MW), .NUM_WIDTH (NW), .OUTPUT_WIDTH (OW),
    .FIFO_DEPTH (DEPTH), .TIMEOUT (TMO)
  ) dut (
    .clk (clk), .rst (rst),
    .job_valid_i (job_valid_i), .job_ready_o (job_ready_o), .job_len_i (job_len_i),
    .op_valid_i (op_valid_i), .op_ready_o (op_ready_o), .op_a_i (op_a_i), .op_b_i (op_b_i),
    .mac_num_valid_o (mac_num_valid_o), .mac_num_o (mac_num_o), .mac_data_o (mac_data_o),
    .mac_data_ready_i (mac_data_ready_i), .mac_result_i (mac_result_i),
    .res_valid_o (res_valid_o), .res_ready_i (res_ready_i),
    .res_data_o (res_data_o), .res_err_o (res_err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboards: operand pairs in push order, expected results in job order.
  typedef struct {
    logic [OW-1:0] data;
    logic          err;
  } res_t;

  logic [15:0] op_q[$];
  res_t        exp_q[$];

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Behavioural MAC: accumulates N pairs after the launch pulse, raises
  // data_ready after mac_delay WAIT cycles, registers the result on that edge.
  int          cur_n       = 0;
  int          mac_delay   = 1;
  bit          mac_hang    = 1'b0;
  int          remaining   = 0;
  int          dly         = -1;
  bit          after_stream = 1'b0;
  logic [OW-1:0] acc       = '0;
  logic [15:0] mdl_pair;
  int          launch_cnt  = 0;
  int          stream_end_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      remaining        = 0;
      dly              = -1;
      acc              = '0;
      after_stream     = 1'b0;
      mac_data_ready_i = 1'b0;
      op_q.delete();
    end else begin
      if (after_stream) begin
        check("mac_data_idle_after_stream", mac_data_o, 16'h0);
        after_stream = 1'b0;
      end
      if (mac_data_ready_i) begin
        mac_data_ready_i = 1'b0;
        mac_result_i     = acc;
      end
      if (mac_num_valid_o) begin
        check("launch_mac_num", mac_num_o, cur_n);
        check("launch_mac_data_zero", mac_data_o, 16'h0);
        launch_cnt++;
        acc       = '0;
        remaining = cur_n;
        dly       = -1;
      end else if (remaining > 0) begin
        mdl_pair = (op_q.size() > 0) ? op_q.pop_front() : 16'hxxxx;
        check("stream_pair", {mac_num_valid_o, mac_data_o}, {1'b0, mdl_pair});
        acc = acc + 32'(mdl_pair[7:0]) * 32'(mdl_pair[15:8]);
        remaining--;
        if (remaining == 0) begin
          after_stream   = 1'b1;
          stream_end_cyc = cyc;
          dly            = mac_hang ? -1 : mac_delay;
        end
      end else if (dly == 0) begin
        mac_data_ready_i = 1'b1;
        dly              = -1;
      end else if (dly > 0) begin
        dly--;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst         = 1'b1;
    job_valid_i = 1'b0;
    op_valid_i  = 1'b0;
    res_ready_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_job_ready"},     job_ready_o,     1'b0);
    check({tag, "_mac_num_valid"}, mac_num_valid_o, 1'b0);
    check({tag, "_mac_num"},       mac_num_o,       8'h0);
    check({tag, "_mac_data"},      mac_data_o,      16'h0);
    check({tag, "_res_valid"},     res_valid_o,     1'b0);
    check({tag, "_res_data"},      res_data_o,      32'h0);
    check({tag, "_res_err"},       res_err_o,       1'b0);
    check({tag, "_op_ready"},      op_ready_o,      1'b1);
  endtask

  task automatic push_op(input logic [7:0] a, input logic [7:0] b);
    int g = 0;
    @(negedge clk);
    op_valid_i = 1'b1;
    op_a_i     = a;
    op_b_i     = b;
    while (!op_ready_o && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!op_ready_o) check("op_push_timeout", op_ready_o, 1'b1);
    op_q.push_back({b, a});
    @(posedge clk);
    #1;
    op_valid_i = 1'b0;
  endtask

  task automatic issue_job(input int n, input res_t e);
    int g = 0;
    @(negedge clk);
    job_len_i   = NW'(n);
    job_valid_i = 1'b1;
    cur_n       = n;
    while (!job_ready_o && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("job_accept", job_ready_o, 1'b1);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    job_valid_i = 1'b0;
  endtask

  int res_cyc = 0;

  // Waits for a result, holds res_ready low for 'hold' cycles checking that
  // the result stays put and job_ready stays low, then takes it.
  task automatic collect(input int hold);
    int   g = 0;
    res_t e;
    @(negedge clk);
    while (!res_valid_o && g < 2000) begin
      @(negedge clk);
      g++;
    end
    res_cyc = cyc;
    check("res_valid_arrives", res_valid_o, 1'b1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '{data: 'x, err: 1'bx};
    for (int i = 0; i < hold; i++) begin
      check("hold_res_valid", res_valid_o, 1'b1);
      check("hold_res_data",  res_data_o,  e.data);
      check("hold_job_ready", job_ready_o, 1'b0);
      @(negedge clk);
    end
    check("res_data", res_data_o, e.data);
    check("res_err",  res_err_o,  e.err);
    res_ready_i = 1'b1;
    @(posedge clk);
    #1;
    res_ready_i = 1'b0;
    @(negedge clk);
    check("res_valid_drop", res_valid_o, 1'b0);
    check("job_ready_after_result", job_ready_o, 1'b1);
  endtask

  typedef struct {
    int            n;
    int            nops;
    logic [7:0]    a [16];
    logic [7:0]    b [16];
    bit            ops_first;
    logic [OW-1:0] exp_data;
    bit            exp_err;
  } vec_t;

  vec_t vecs [6];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   l0;
    int   g;
    int   n;
    logic [OW-1:0] gold;
    logic [7:0] ra [16];
    logic [7:0] rb [16];

    // Vector table: length, operands, ordering, expected result.
    vecs[0] = '{n: 4,  nops: 4,  a: '{default: 0}, b: '{default: 0}, ops_first: 0, exp_data: 100,   exp_err: 0};
    vecs[0].a[0] = 1; vecs[0].b[0] = 2; vecs[0].a[1] = 3; vecs[0].b[1] = 4;
    vecs[0].a[2] = 5; vecs[0].b[2] = 6; vecs[0].a[3] = 7; vecs[0].b[3] = 8;
    vecs[1] = '{n: 1,  nops: 1,  a: '{default: 255}, b: '{default: 255}, ops_first: 1, exp_data: 65025, exp_err: 0};
    vecs[2] = '{n: 0,  nops: 0,  a: '{default: 0}, b: '{default: 0}, ops_first: 0, exp_data: 0,     exp_err: 1};
    vecs[3] = '{n: 17, nops: 0,  a: '{default: 0}, b: '{default: 0}, ops_first: 0, exp_data: 0,     exp_err: 1};
    vecs[4] = '{n: 16, nops: 16, a: '{default: 0}, b: '{default: 2}, ops_first: 1, exp_data: 272,   exp_err: 0};
    for (int i = 0; i < 16; i++) vecs[4].a[i] = 8'(i + 1);
    vecs[5] = '{n: 3,  nops: 3,  a: '{default: 0}, b: '{default: 0}, ops_first: 0, exp_data: 1400,  exp_err: 0};
    vecs[5].a[0] = 10; vecs[5].b[0] = 10; vecs[5].a[1] = 20; vecs[5].b[1] = 20;
    vecs[5].a[2] = 30; vecs[5].b[2] = 30;

    do_reset();
    check_reset_outputs("reset");

    for (int i = 0; i < 6; i++) begin
      l0 = launch_cnt;
      if (vecs[i].ops_first) begin
        for (int k = 0; k < vecs[i].nops; k++) push_op(vecs[i].a[k], vecs[i].b[k]);
        issue_job(vecs[i].n, '{data: vecs[i].exp_data, err: vecs[i].exp_err});
      end else begin
        fork
          issue_job(vecs[i].n, '{data: vecs[i].exp_data, err: vecs[i].exp_err});
          for (int k = 0; k < vecs[i].nops; k++) push_op(vecs[i].a[k], vecs[i].b[k]);
        join
      end
      collect(0);
      check("launch_count", launch_cnt - l0, vecs[i].exp_err ? 0 : 1);
    end

    // Slow producer: one pair every 3 cycles, no launch before the third.
    l0 = launch_cnt;
    issue_job(3, '{data: 68, err: 1'b0});
    for (int k = 0; k < 3; k++) begin
      repeat (2) @(negedge clk);
      check("no_early_launch", launch_cnt - l0, 0);
      push_op(8'(2 * k + 2), 8'(2 * k + 3));
    end
    collect(0);
    check("slow_launch_count", launch_cnt - l0, 1);

    // Result backpressure for 10 cycles.
    fork
      issue_job(2, '{data: 82, err: 1'b0});
      begin push_op(9, 9); push_op(1, 1); end
    join
    collect(10);

    // MAC never answers: timeout error after TIMEOUT cycles in WAIT.
    mac_hang = 1'b1;
    fork
      issue_job(2, '{data: 0, err: 1'b1});
      begin push_op(3, 3); push_op(4, 4); end
    join
    collect(0);
    check("timeout_latency_in_range",
          ((res_cyc - stream_end_cyc) >= TMO) && ((res_cyc - stream_end_cyc) <= TMO + 3), 1'b1);
    mac_hang = 1'b0;

    // Reset in the middle of a stream, then prove the FIFO was flushed.
    for (int k = 0; k < 8; k++) push_op(8'(k + 1), 8'(k + 1));
    issue_job(8, '{data: 204, err: 1'b0});
    g = 0;
    while (!(remaining > 1 && remaining < 6) && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("reached_stream", remaining > 1 && remaining < 6, 1'b1);
    do_reset();
    check_reset_outputs("midstream_reset");
    fork
      issue_job(1, '{data: 35, err: 1'b0});
      push_op(5, 7);
    join
    collect(1);

    // Randomised jobs, including illegal lengths, delays and backpressure.
    for (int j = 0; j < 8; j++) begin
      n         = $urandom_range(0, 18);
      mac_delay = $urandom_range(0, 5);
      gold      = '0;
      for (int k = 0; k < 16; k++) begin
        ra[k] = 8'($urandom_range(0, 255));
        rb[k] = 8'($urandom_range(0, 255));
        if (k < n) gold = gold + 32'(ra[k]) * 32'(rb[k]);
      end
      l0 = launch_cnt;
      if (n == 0 || n > DEPTH) begin
        issue_job(n, '{data: 0, err: 1'b1});
      end else begin
        fork
          issue_job(n, '{data: gold, err: 1'b0});
          for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            push_op(ra[k], rb[k]);
          end
        join
      end
      collect($urandom_range(0, 4));
      check("rand_launch_count", launch_cnt - l0, (n == 0 || n > DEPTH) ? 0 : 1);
      check("rand_op_queue_drained", op_q.size(), 0);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
